// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline request, aux-unit offer, RF write port, hazard query, status.
// Latency: none, this is wiring only.
// Backpressure: aux_ready back toward the aux unit; pipe_stall back toward the pipeline.
interface wb_port_arbiter_if;
    logic        pipe_wr_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_value;
    logic        aux_valid;
    logic [4:0]  aux_rd;
    logic [31:0] aux_value;
    logic        aux_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [4:0]  q_rd;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        hazard_rd;
    logic        pipe_stall;
    logic        proto_err;

    modport master (
        output pipe_wr_en, pipe_rd, pipe_value,
        output aux_valid, aux_rd, aux_value,
        input  aux_ready,
        input  rf_we, rf_rd, rf_wd,
        output q_rs1, q_rs2, q_rd,
        input  hazard_rs1, hazard_rs2, hazard_rd,
        input  pipe_stall, proto_err
    );

    modport slave (
        input  pipe_wr_en, pipe_rd, pipe_value,
        input  aux_valid, aux_rd, aux_value,
        output aux_ready,
        output rf_we, rf_rd, rf_wd,
        input  q_rs1, q_rs2, q_rd,
        output hazard_rs1, hazard_rs2, hazard_rd,
        output pipe_stall, proto_err
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one RF write port between the pipeline and a buffered long-latency unit; WB_PORT_ARBITER_STATS_EN adds stall_cycles.
// Latency: pipeline writes same cycle; aux results drain no earlier than the cycle after acceptance.
// Backpressure: aux_ready from registered occupancy; pipe_stall once the buffer head has starved STARVE_LIMIT cycles.
module wb_port_arbiter #(
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    wb_port_arbiter_if.slave bus
`ifdef WB_PORT_ARBITER_STATS_EN
    ,
    output logic [15:0] stall_cycles
`endif
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] LAST_C   = PW'(BUF_DEPTH - 1);

    logic [4:0]           r_rd  [BUF_DEPTH];
    logic [31:0]          r_val [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_vld;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [SW-1:0]        r_starve;
    logic                 r_proto_err;

    logic w_pipe_req;
    logic w_nonempty;
    logic w_stall;
    logic w_pipe_grant;
    logic w_head_grant;
    logic w_ready;
    logic w_enq;
    logic w_haz_rs1;
    logic w_haz_rs2;
    logic w_haz_rd;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign w_pipe_req   = bus.pipe_wr_en && (bus.pipe_rd != 5'd0);
    assign w_nonempty   = (r_count != '0);
    assign w_stall      = reset && (r_starve == STARVE_C);
    // During a stall the head wins even over a pipeline request.
    assign w_pipe_grant = reset && !w_stall && w_pipe_req;
    assign w_head_grant = reset && !w_pipe_grant && w_nonempty;
    assign w_ready      = reset && (r_count < DEPTH_C);
    assign w_enq        = bus.aux_valid && w_ready && (bus.aux_rd != 5'd0);

    assign bus.aux_ready  = w_ready;
    assign bus.pipe_stall = w_stall;
    assign bus.proto_err  = r_proto_err;
    assign bus.rf_we      = w_pipe_grant || w_head_grant;
    assign bus.rf_rd      = w_pipe_grant ? bus.pipe_rd    : (w_head_grant ? r_rd[r_head]  : 5'd0);
    assign bus.rf_wd      = w_pipe_grant ? bus.pipe_value : (w_head_grant ? r_val[r_head] : 32'd0);

    always_comb begin
        w_haz_rs1 = 1'b0;
        w_haz_rs2 = 1'b0;
        w_haz_rd  = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] == bus.q_rs1) && (bus.q_rs1 != 5'd0)) w_haz_rs1 = 1'b1;
            if (r_vld[i] && (r_rd[i] == bus.q_rs2) && (bus.q_rs2 != 5'd0)) w_haz_rs2 = 1'b1;
            if (r_vld[i] && (r_rd[i] == bus.q_rd)  && (bus.q_rd  != 5'd0)) w_haz_rd  = 1'b1;
        end
    end

    assign bus.hazard_rs1 = w_haz_rs1;
    assign bus.hazard_rs2 = w_haz_rs2;
    assign bus.hazard_rd  = w_haz_rd;

    // Payload storage needs no reset; r_vld gates every use of it.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_rd[r_tail]  <= bus.aux_rd;
            r_val[r_tail] <= bus.aux_value;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_vld       <= '0;
            r_starve    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= next_ptr(r_tail);
            end
            if (w_head_grant) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= next_ptr(r_head);
            end
            if (w_enq && !w_head_grant)
                r_count <= r_count + 1'b1;
            else if (!w_enq && w_head_grant)
                r_count <= r_count - 1'b1;
            if (!w_nonempty || w_head_grant)
                r_starve <= '0;
            else if (r_starve != STARVE_C)
                r_starve <= r_starve + 1'b1;
            if (w_stall && w_pipe_req)
                r_proto_err <= 1'b1;
        end
    end

`ifdef WB_PORT_ARBITER_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clock) begin
        if (!reset)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != 16'hFFFF))
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table, starvation/protocol sequences, randomized scoreboard run.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_wb_port_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst;
        bit          pwe;
        logic [4:0]  prd;
        logic [31:0] pval;
        bit          av;
        logic [4:0]  ard;
        logic [31:0] aval;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [4:0]  qd;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          ardy;
        bit          stall;
        bit          h1;
        bit          h2;
        bit          hd;
        bit          perr;
    } vec_t;

    vec_t tbl [18];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    ent_t sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit pwe, input logic [4:0] prd, input logic [31:0] pval,
                         input bit av, input logic [4:0] ard, input logic [31:0] aval,
                         input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd);
        rst_n          = r;
        bus.pipe_wr_en = pwe;
        bus.pipe_rd    = prd;
        bus.pipe_value = pval;
        bus.aux_valid  = av;
        bus.aux_rd     = ard;
        bus.aux_value  = aval;
        bus.q_rs1      = q1;
        bus.q_rs2      = q2;
        bus.q_rd       = qd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic starve_seq(input bit hold_pipe);
        next_cycle();
        drive(1, 0, 0, 0, 1, 12, 32'hC0C0_0012, 0, 0, 0);
        @(negedge clk);
        chk("starve_accept_ready", {31'd0, bus.aux_ready}, 1);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            drive(1, 1, 7, 32'h7000_0000 + c, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("starve_pipe_stall_low", {31'd0, bus.pipe_stall}, 0);
            chk("starve_pipe_rd", {27'd0, bus.rf_rd}, 7);
        end
        next_cycle();
        drive(1, hold_pipe, 7, 32'h7000_0009, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("starve_stall_cycle9", {31'd0, bus.pipe_stall}, 1);
        chk("starve_head_we", {31'd0, bus.rf_we}, 1);
        chk("starve_head_rd", {27'd0, bus.rf_rd}, 12);
        chk("starve_head_wd", bus.rf_wd, 32'hC0C0_0012);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("starve_stall_cycle10", {31'd0, bus.pipe_stall}, 0);
        chk("starve_we_after", {31'd0, bus.rf_we}, 0);
        chk("proto_err_after_stall", {31'd0, bus.proto_err}, {31'd0, hold_pipe});
        if (hold_pipe) begin
            for (int c = 0; c < 3; c++) begin
                next_cycle();
                @(negedge clk);
                chk("proto_err_sticky", {31'd0, bus.proto_err}, 1);
            end
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("proto_err_cleared", {31'd0, bus.proto_err}, 0);
        end
    endtask

    // One scoreboard cycle: inputs already driven, checks at the falling edge.
    task automatic sb_cycle();
        bit pipe_req;
        ent_t e;
        @(negedge clk);
        pipe_req = bus.pipe_wr_en && (bus.pipe_rd != 0);
        chk("sb_aux_ready", {31'd0, bus.aux_ready}, {31'd0, (sb.size() < 2)});
        if (pipe_req && !bus.pipe_stall) begin
            chk("sb_pipe_we", {31'd0, bus.rf_we}, 1);
            chk("sb_pipe_rd", {27'd0, bus.rf_rd}, {27'd0, bus.pipe_rd});
            chk("sb_pipe_wd", bus.rf_wd, bus.pipe_value);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_aux_we", {31'd0, bus.rf_we}, 1);
            chk("sb_aux_rd", {27'd0, bus.rf_rd}, {27'd0, e.rd});
            chk("sb_aux_wd", bus.rf_wd, e.val);
        end else begin
            chk("sb_idle_we", {31'd0, bus.rf_we}, 0);
        end
        if (bus.aux_valid && bus.aux_ready && (bus.aux_rd != 0)) begin
            e.rd  = bus.aux_rd;
            e.val = bus.aux_value;
            sb.push_back(e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl[0]  = '{0,0,0,0,            0,0,0,             0,0,0,  0,0,0,              0,0, 0,0,0, 0};
        tbl[1]  = '{1,0,0,0,            1,5,32'hDEAD_BEEF, 0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[2]  = '{1,0,0,0,            0,0,0,             5,0,0,  1,5,32'hDEAD_BEEF,  1,0, 1,0,0, 0};
        tbl[3]  = '{1,0,0,0,            0,0,0,             5,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[4]  = '{1,0,0,0,            1,3,32'h3333,      0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[5]  = '{1,0,0,0,            1,4,32'h4444,      0,0,0,  1,3,32'h3333,       1,0, 0,0,0, 0};
        tbl[6]  = '{1,0,0,0,            0,0,0,             0,0,0,  1,4,32'h4444,       1,0, 0,0,0, 0};
        tbl[7]  = '{1,0,0,0,            0,0,0,             0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[8]  = '{1,1,7,32'h7777,     1,9,32'h9999,      9,0,0,  1,7,32'h7777,       1,0, 0,0,0, 0};
        tbl[9]  = '{1,1,7,32'h7777,     1,10,32'hAAAA,     9,0,9,  1,7,32'h7777,       1,0, 1,0,1, 0};
        tbl[10] = '{1,1,7,32'h7777,     1,11,32'hBBBB,     0,10,0, 1,7,32'h7777,       0,0, 0,1,0, 0};
        tbl[11] = '{0,1,7,32'h7777,     1,11,32'hBBBB,     0,0,0,  0,0,0,              0,0, 0,0,0, 0};
        tbl[12] = '{1,0,0,0,            0,0,0,             0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[13] = '{1,0,0,0,            0,0,0,             9,10,0, 0,0,0,              1,0, 0,0,0, 0};
        tbl[14] = '{1,0,0,0,            1,0,32'h1234,      0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[15] = '{1,0,0,0,            0,0,0,             0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[16] = '{1,1,0,32'h5555,     0,0,0,             0,0,0,  0,0,0,              1,0, 0,0,0, 0};
        tbl[17] = '{1,1,31,32'h5555,    0,0,0,             0,0,0,  1,31,32'h5555,      1,0, 0,0,0, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            next_cycle();
            drive(tbl[i].rst, tbl[i].pwe, tbl[i].prd, tbl[i].pval, tbl[i].av, tbl[i].ard,
                  tbl[i].aval, tbl[i].q1, tbl[i].q2, tbl[i].qd);
            @(negedge clk);
            chk($sformatf("v%0d_rf_we", i), {31'd0, bus.rf_we}, {31'd0, tbl[i].we});
            if (tbl[i].we) begin
                chk($sformatf("v%0d_rf_rd", i), {27'd0, bus.rf_rd}, {27'd0, tbl[i].rd});
                chk($sformatf("v%0d_rf_wd", i), bus.rf_wd, tbl[i].wd);
            end
            chk($sformatf("v%0d_aux_ready", i), {31'd0, bus.aux_ready}, {31'd0, tbl[i].ardy});
            chk($sformatf("v%0d_pipe_stall", i), {31'd0, bus.pipe_stall}, {31'd0, tbl[i].stall});
            chk($sformatf("v%0d_hazard_rs1", i), {31'd0, bus.hazard_rs1}, {31'd0, tbl[i].h1});
            chk($sformatf("v%0d_hazard_rs2", i), {31'd0, bus.hazard_rs2}, {31'd0, tbl[i].h2});
            chk($sformatf("v%0d_hazard_rd", i), {31'd0, bus.hazard_rd}, {31'd0, tbl[i].hd});
            chk($sformatf("v%0d_proto_err", i), {31'd0, bus.proto_err}, {31'd0, tbl[i].perr});
        end

        starve_seq(1'b0);
        starve_seq(1'b1);

        for (int i = 0; i < 300; i++) begin
            next_cycle();
            drive(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'hF000_0000 + i,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'hA000_0000 + i, 0, 0, 0);
            sb_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            sb_cycle();
        end
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end
endmodule
